// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor computing a-b, LSB first, one bit per clock.
// Each bit step chains two half-subtractors with a registered borrow between steps.
// Result and final borrow are held until the next operation completes.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic [WIDTH-1:0] res_sh_next;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             busy_reg;
  logic             done_reg;

  // Full-subtractor step built from two half-subtractor stages.
  logic x_bit, y_bit;
  logic hs1_diff, hs1_borrow;
  logic hs2_diff, hs2_borrow;
  logic bit_borrow;
  logic last_bit;

  assign x_bit       = a_sh_reg[0];
  assign y_bit       = b_sh_reg[0];
  assign hs1_diff    = x_bit ^ y_bit;
  assign hs1_borrow  = ~x_bit & y_bit;
  assign hs2_diff    = hs1_diff ^ borrow_reg;
  assign hs2_borrow  = ~hs1_diff & borrow_reg;
  assign bit_borrow  = hs1_borrow | hs2_borrow;
  assign res_sh_next = {hs2_diff, res_sh_reg[WIDTH-1:1]};
  assign last_bit    = (cnt_reg == LAST_BIT);

  // Next-state logic: start only matters in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == SHIFT);
      done_reg  <= (state_next == DONE);
    end
  end

  // Operand capture, per-bit shifting and result latch on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      res_sh_reg     <= '0;
      borrow_reg     <= 1'b0;
      cnt_reg        <= '0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
        SHIFT: begin
          res_sh_reg <= res_sh_next;
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          borrow_reg <= bit_borrow;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_bit) begin
            diff_reg       <= res_sh_next;
            borrow_out_reg <= bit_borrow;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomized checks of serial_sub at WIDTH=8, plus an exhaustive WIDTH=2 sweep.
module tb_serial_sub;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(2)) bus2 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 op and wait (bounded) for done; returns the observed result.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic bo, output logic ok);
    ok = 1'b0;
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (bus8.done === 1'b1) ok = 1'b1;
    end
    d  = bus8.diff;
    bo = bus8.borrow_out;
    tick();
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b,
                         output logic [1:0] d, output logic bo, output logic ok);
    ok = 1'b0;
    bus2.a = a;
    bus2.b = b;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus2.done === 1'b1) ok = 1'b1;
    end
    d  = bus2.diff;
    bo = bus2.borrow_out;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow_out} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset8: busy=%b done=%b diff=%h bo=%b, required all 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    end
    tests_run++;
    if ({bus2.busy, bus2.done, bus2.diff, bus2.borrow_out} !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset2: busy=%b done=%b diff=%h bo=%b, required all 0",
               bus2.busy, bus2.done, bus2.diff, bus2.borrow_out);
    end
    $display("[TB] reset checked");
  endtask

  // 0x05-0x03 with cycle-exact busy/done timing.
  task automatic test_basic_timing();
    int busy_cnt;
    busy_cnt = 0;
    bus8.a = 8'h05;
    bus8.b = 8'h03;
    bus8.start = 1'b1;
    tick();                       // E0
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin   // cycles after E0..E7
      if (bus8.busy === 1'b1) busy_cnt++;
      tests_run++;
      if (bus8.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL early_done: cycle %0d done=%b, required 0", i, bus8.done);
      end
      tick();
    end
    // now just after E8: DONE cycle
    tests_run++;
    if (busy_cnt != 8) begin
      tests_failed++;
      $display("FAIL busy_len: got %0d cycles, required 8", busy_cnt);
    end
    tests_run++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_time: done=%b busy=%b, required done=1 busy=0", bus8.done, bus8.busy);
    end
    tests_run++;
    if (bus8.diff !== 8'h02 || bus8.borrow_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_5m3: diff=%h bo=%b, required 02/0", bus8.diff, bus8.borrow_out);
    end
    tick();
    tests_run++;
    if (bus8.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", bus8.done);
    end
    $display("[TB] op 05-03 -> diff=%h bo=%b", bus8.diff, bus8.borrow_out);
  endtask

  task automatic test_corners();
    logic [7:0] va [6] = '{8'h03, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h05};
    logic [7:0] vb [6] = '{8'h05, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h03};
    logic [7:0] ed [6] = '{8'hFE, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h02};
    logic       eb [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] d;
    logic       bo, ok;
    for (int i = 0; i < 6; i++) begin
      run_op8(va[i], vb[i], d, bo, ok);
      tests_run++;
      if (!ok || d !== ed[i] || bo !== eb[i]) begin
        tests_failed++;
        $display("FAIL corner %h-%h: done_seen=%b diff=%h bo=%b, required %h/%b",
                 va[i], vb[i], ok, d, bo, ed[i], eb[i]);
      end else
        $display("[TB] op %h-%h -> diff=%h bo=%b", va[i], vb[i], d, bo);
    end
  endtask

  task automatic test_start_ignored();
    bus8.a = 8'h05;
    bus8.b = 8'h03;
    bus8.start = 1'b1;
    tick();                       // E0
    bus8.start = 1'b0;
    tick(); tick(); tick();       // E1..E3
    bus8.a = 8'hFF;
    bus8.b = 8'h00;
    bus8.start = 1'b1;
    tick();                       // E4: ignored
    bus8.start = 1'b0;
    tick(); tick(); tick(); tick(); // E5..E8 -> DONE
    tests_run++;
    if (bus8.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ign_done: done=%b, required 1", bus8.done);
    end
    bus8.a = 8'h10;
    bus8.b = 8'h01;
    bus8.start = 1'b1;
    tick();                       // E9: start in DONE ignored
    bus8.start = 1'b0;
    tests_run++;
    if (bus8.diff !== 8'h02 || bus8.borrow_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL ign_result: diff=%h bo=%b, required 02/0", bus8.diff, bus8.borrow_out);
    end
    tick();
    tests_run++;
    if (bus8.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ign_done_start: busy=%b, required 0", bus8.busy);
    end
    $display("[TB] op 05-03 with mid-op starts -> diff=%h bo=%b", bus8.diff, bus8.borrow_out);
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    bus8.a = 8'h09;
    bus8.b = 8'h04;
    bus8.start = 1'b1;
    for (int c = 0; c < 35; c++) begin
      tick();
      if (bus8.done === 1'b1) pulses.push_back(c);
    end
    bus8.start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    tests_run++;
    if (pulses.size() < 3) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d done pulses, required >= 3", pulses.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (pulses[i] - pulses[i-1] != 10) begin
          tests_failed++;
          $display("FAIL b2b_spacing: %0d cycles, required 10", pulses[i] - pulses[i-1]);
        end
      end
    end
    tests_run++;
    if (bus8.diff !== 8'h05 || bus8.borrow_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_result: diff=%h bo=%b, required 05/0", bus8.diff, bus8.borrow_out);
    end
    $display("[TB] back-to-back 09-04 x%0d -> diff=%h bo=%b", pulses.size(), bus8.diff, bus8.borrow_out);
  endtask

  task automatic test_reset_mid();
    logic       seen_done;
    logic [7:0] d;
    logic       bo, ok;
    seen_done = 1'b0;
    bus8.a = 8'hAA;
    bus8.b = 8'h11;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick(); tick();   // 4 bits shifted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy=%b done=%b diff=%h bo=%b, required 0/0/00/0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus8.done === 1'b1) seen_done = 1'b1;
    end
    tests_run++;
    if (seen_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_done: done pulse seen=%b, required 0", seen_done);
    end
    run_op8(8'h10, 8'h01, d, bo, ok);
    tests_run++;
    if (!ok || d !== 8'h0F || bo !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset 10-01: done_seen=%b diff=%h bo=%b, required 0f/0", ok, d, bo);
    end
    $display("[TB] op 10-01 after abort -> diff=%h bo=%b", d, bo);
  endtask

  task automatic test_random();
    logic [7:0] a, b, d, ed;
    logic       bo, eb, ok;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ed = a - b;
      eb = (a < b);
      run_op8(a, b, d, bo, ok);
      tests_run++;
      if (!ok || d !== ed || bo !== eb) begin
        tests_failed++;
        $display("FAIL rand %h-%h: done_seen=%b diff=%h bo=%b, required %h/%b", a, b, ok, d, bo, ed, eb);
      end else
        $display("[TB] rand %h-%h -> diff=%h bo=%b", a, b, d, bo);
    end
  endtask

  task automatic test_width2();
    logic [1:0] a, b, d, ed;
    logic       bo, eb, ok;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        a  = 2'(ia);
        b  = 2'(ib);
        ed = a - b;
        eb = (ia < ib);
        run_op2(a, b, d, bo, ok);
        tests_run++;
        if (!ok || d !== ed || bo !== eb) begin
          tests_failed++;
          $display("FAIL w2 %0d-%0d: done_seen=%b diff=%0d bo=%b, required %0d/%b",
                   ia, ib, ok, d, bo, ed, eb);
        end else
          $display("[TB] w2 %0d-%0d -> diff=%0d bo=%b", ia, ib, d, bo);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    test_reset();
    test_basic_timing();
    test_corners();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width2();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
